// File: rtl/rr_pkg.sv
// Shared types and helpers for the 1:N round-robin packet distributor.
package rr_pkg;

  typedef enum logic {IDLE, LOCKED} dist_state_e;

  // One-hot vectors are never narrower than a single bit.
  function automatic int unsigned oh_width(input int unsigned n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/rr_pick_free.sv
// Combinational round-robin pick: first free slot above last_grant, else lowest free slot.
module rr_pick_free #(
  parameter int unsigned N_REQ = 8
) (
  input  logic [N_REQ-1:0] free_i,
  input  logic [N_REQ-1:0] last_grant_i,
  output logic [N_REQ-1:0] grant_o
);

  logic [N_REQ-1:0] above;
  logic [N_REQ-1:0] hi;
  logic [N_REQ-1:0] hi_pick;
  logic [N_REQ-1:0] lo_pick;
  logic             seen;

  always_comb begin
    above = '0;
    seen  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      above[i] = seen;
      seen     = seen | last_grant_i[i];
    end
  end

  // x & -x isolates the lowest set bit.
  assign hi      = free_i & above;
  assign hi_pick = hi & (~hi + N_REQ'(1));
  assign lo_pick = free_i & (~free_i + N_REQ'(1));
  assign grant_o = (|hi) ? hi_pick : lo_pick;

endmodule

// File: rtl/rr_distributor.sv
// 1:N round-robin packet distributor; whole packets go to one output, one register slot per output.
module rr_distributor
  import rr_pkg::*;
#(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned DATAW = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATAW-1:0]       in_data_i,
  input  logic                   in_last_i,
  output logic [N_REQ-1:0]       out_valid_o,
  input  logic [N_REQ-1:0]       out_ready_i,
  output logic [N_REQ*DATAW-1:0] out_data_o,
  output logic [N_REQ-1:0]       out_last_o
);

  localparam int unsigned OhW = oh_width(N_REQ);
  // Top bit set so the first packet after reset lands on output 0.
  localparam logic [OhW-1:0] GrantRst = ~({OhW{1'b1}} >> 1);

  dist_state_e    state_q, state_d;
  logic [OhW-1:0] lock_q, lock_d;
  logic [OhW-1:0] last_grant_q, last_grant_d;
  logic [OhW-1:0] free;
  logic [OhW-1:0] pick;
  logic [OhW-1:0] target;
  logic [OhW-1:0] write;
  logic           accept;

  assign free = ~out_valid_o | out_ready_i;

  rr_pick_free #(
    .N_REQ (OhW)
  ) u_pick (
    .free_i       (free),
    .last_grant_i (last_grant_q),
    .grant_o      (pick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      lock_q       <= '0;
      last_grant_q <= GrantRst;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_last_i) begin
            last_grant_d = target;
          end else begin
            lock_d  = target;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (accept && in_last_i) begin
          last_grant_d = lock_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In IDLE pick is a free slot whenever any slot is free, so one expression covers both states.
  always_comb begin
    target     = (state_q == LOCKED) ? lock_q : pick;
    in_ready_o = rst_ni & (|(free & target));
    accept     = in_valid_i & in_ready_o;
    write      = accept ? target : '0;
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    logic             valid_q;
    logic             last_q;
    logic [DATAW-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
      end else if (write[i]) begin
        valid_q <= 1'b1;
        last_q  <= in_last_i;
        data_q  <= in_data_i;
      end else if (out_ready_i[i]) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid_o[i]                 = valid_q;
    assign out_last_o[i]                  = last_q;
    assign out_data_o[i*DATAW +: DATAW]   = data_q;
  end

endmodule

// File: tb/tb_rr_distributor.sv
// Scoreboard bench for rr_distributor with N_REQ=4, DATAW=8 and hand-computed target ports.
module tb_rr_distributor;

  localparam int unsigned NReq  = 4;
  localparam int unsigned DataW = 8;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data  = 8'h00;
  logic        in_last  = 1'b0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'h0;
  logic [31:0] out_data;
  logic [3:0]  out_last;

  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned waits;

  logic [8:0]  exp_q [NReq][$];

  logic [3:0]  pv = 4'h0;
  logic [3:0]  pr = 4'h0;
  logic [3:0]  pl = 4'h0;
  logic [7:0]  pd [NReq];

  rr_distributor #(
    .N_REQ (NReq),
    .DATAW (DataW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every consumer handshake and checks held slots stay stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv <= 4'h0;
      pr <= 4'h0;
    end else begin
      for (int i = 0; i < int'(NReq); i++) begin
        if (pv[i] && !pr[i])
          chk($sformatf("hold%0d", i), 32'({out_valid[i], out_last[i], out_data[i*8 +: 8]}),
              32'({1'b1, pl[i], pd[i]}));
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0)
            chk($sformatf("sb_nonempty%0d", i), 32'(exp_q[i].size()), 32'd1);
          else
            chk($sformatf("sb_port%0d", i), 32'({out_last[i], out_data[i*8 +: 8]}),
                32'(exp_q[i].pop_front()));
        end
        pv[i] <= out_valid[i];
        pr[i] <= out_ready[i];
        pl[i] <= out_last[i];
        pd[i] <= out_data[i*8 +: 8];
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input int p);
    bit ok;
    ok       = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!ok && waits < 40) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        exp_q[p].push_back({l, d});
      end
      @(posedge clk);
      #1;
      if (!ok) waits++;
    end
    in_valid = 1'b0;
    chk($sformatf("accept_%0h", d), 32'(ok), 32'd1);
    if (ok)
      chk($sformatf("lat_%0h", d), 32'({out_valid[p], out_last[p], out_data[p*8 +: 8]}),
          32'({1'b1, l, d}));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 4'hF;

    // Single-beat packets rotate 0,1,2,3,0 with no stalls.
    for (int k = 0; k < 5; k++) begin
      send(8'hA0 + 8'(k), 1'b1, k % 4);
      chk("a_nowait", waits, 32'd0);
    end
    // Fillers advance last_grant to 3 so the 3-beat packet lands on output 0.
    send(8'hB1, 1'b1, 1);
    send(8'hB2, 1'b1, 2);
    send(8'hB3, 1'b1, 3);
    send(8'h10, 1'b0, 0);
    send(8'h11, 1'b0, 0);
    send(8'h12, 1'b1, 0);
    chk("pkt_nowait", waits, 32'd0);
    send(8'h20, 1'b1, 1);

    // Bring last_grant back to 0, park 0x55 on stalled output 1, then 0x66 must skip to 2.
    send(8'hD2, 1'b1, 2);
    send(8'hD3, 1'b1, 3);
    send(8'hD0, 1'b1, 0);
    out_ready = 4'b1101;
    send(8'h55, 1'b1, 1);
    send(8'hE2, 1'b1, 2);
    send(8'hE3, 1'b1, 3);
    send(8'hE0, 1'b1, 0);
    send(8'h66, 1'b1, 2);
    chk("hold55", 32'({out_valid[1], out_data[15:8]}), 32'({1'b1, 8'h55}));
    out_ready = 4'hF;
    idle(2);

    // last_grant=2: fill all slots 3,0,1,2 with consumers stalled.
    out_ready = 4'h0;
    send(8'hF3, 1'b1, 3);
    send(8'hF0, 1'b1, 0);
    send(8'hF1, 1'b1, 1);
    send(8'hF2, 1'b1, 2);
    in_valid = 1'b1;
    in_data  = 8'hC0;
    in_last  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("full_stall", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 4'b0100;
    send(8'hC0, 1'b1, 2);
    chk("refill_same_cycle", waits, 32'd0);
    out_ready = 4'hF;
    idle(2);

    // last_grant=2: packet locks to output 3, which then stalls.
    send(8'h30, 1'b0, 3);
    out_ready = 4'b0111;
    in_valid  = 1'b1;
    in_data   = 8'h31;
    in_last   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("lock_stall", 32'(in_ready), 32'd0);
      chk("no_leak", 32'(out_valid[2:0]), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 4'hF;
    send(8'h31, 1'b0, 3);
    send(8'h32, 1'b1, 3);

    // last_grant=3: mid-packet reset on output 0.
    send(8'h70, 1'b0, 0);
    out_ready = 4'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_data", out_data, 32'd0);
    for (int i = 0; i < int'(NReq); i++) exp_q[i].delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    send(8'h80, 1'b1, 0);
    send(8'h81, 1'b1, 1);
    idle(3);
    chk("drained", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()),
        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_distributor.md
Name: rr_distributor

Overview:
- 1:N round-robin dispatcher. Takes one valid/ready packet stream (with a last flag) and spreads whole packets across N_REQ consumer ports.
- It is the fan-out counterpart of the team's N:1 round-robin arbiter/mux; it drives the consumer side.
- Each output has a one-entry register slot. Packets are never split across outputs.

Parameters:
- N_REQ, 8, number of output consumers (>=1)
- DATAW, 64, width of the data bus

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  upstream beat accepted when in_valid && in_ready
- in_data  in  DATAW  upstream beat payload
- in_last  in  1  final beat of packet
- out_valid  out  N_REQ  per-output slot valid
- out_ready  in  N_REQ  per-output consumer ready
- out_data  out  N_REQ*DATAW  slot i payload occupies bits [i*DATAW +: DATAW]
- out_last  out  N_REQ  per-output last flag

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - out_valid=0, out_last=0, out_data=0.
  - state=IDLE.
  - last_grant one-hot = bit N_REQ-1, so the first packet goes to output 0.
- Slot i is free this cycle when !out_valid[i] || out_ready[i]. Draining and refilling in the same cycle is allowed, giving 1 beat/cycle throughput.
- Round-robin pick in IDLE:
  - Candidates are the free slots strictly above last_grant first, then wrap to the lowest free slot.
  - target is one-hot; it is 0 when no slot is free.
- States (dist_state_e):
  - IDLE: in_ready = |free. On accept, the beat is written to target. If in_last=1, last_grant<=target and stay in IDLE. If in_last=0, lock<=target and go to LOCKED.
  - LOCKED: target=lock, in_ready = free[lock]. Accepted beats go to lock only. On accept with in_last=1, last_grant<=lock and go to IDLE.
  - last_grant updates only at packet end.
- Latency: a beat accepted at edge k shows out_valid at edge k+1 (1 cycle).
- in_ready never depends on in_valid. It may depend combinationally on out_ready.
- Output hold: while out_valid[i] && !out_ready[i], out_data[i] and out_last[i] stay stable.
  - A slot clears on out_ready when it is not refilled in the same cycle.
- Boundaries:
  - All slots full and stalled: in_ready=0.
  - Locked slot stalled while other slots are free: in_ready=0. Nothing leaks to another output.
  - in_valid drops mid-packet: stay LOCKED indefinitely.
  - N_REQ=1: always output 0, lock is trivial.
  - Reset mid-packet: slot contents and lock are discarded immediately; in_ready is low during reset.
- No X on outputs after reset. Unused out_data bits are held at their last value.

Decomposition:
- Package rr_pkg: typedef enum logic {IDLE, LOCKED} dist_state_e; localparam helper for the one-hot width.
- Sub-module rr_pick_free: combinational round-robin pick over a free vector relative to a one-hot last_grant. Ports: free, last_grant, grant; same parameters.
- Per-slot registers stay in the top module, built with a generate loop.

Test Plan (N_REQ=4, DATAW=8):
- Reset release, then single-beat packets 0xA0..0xA4 back-to-back, all out_ready=1 -> 0xA0..0xA3 appear on outputs 0,1,2,3 one cycle after each accept, then 0xA4 on output 0; in_ready=1 throughout.
- 3-beat packet 0x10,0x11,0x12 (last on 0x12), out_ready=1 -> all three beats on output 0 on consecutive cycles. The next single-beat packet 0x20 goes to output 1.
- Output 1 holds 0x55 with out_ready[1]=0, last_grant=0, next packet 0x66 -> 0x66 lands on output 2. Output 1 keeps 0x55 stable.
- Fill all 4 slots with out_ready=0 -> in_ready=0 and data held. Raise out_ready[2] -> in_ready=1 in the same cycle, and the new beat replaces slot 2 at the next edge.
- Packet locked to output 3 with out_ready[3]=0 and outputs 0-2 free -> in_ready=0 and no out_valid change on 0-2. Release out_ready[3] -> beats resume on output 3.
- Assert rst_n=0 mid-packet with slots valid -> out_valid=0 asynchronously. After release, the next packet goes to output 0.
